// File: rtl/cnt_wrap_mon_if.sv
// Read-side port bundle of cnt_wrap_mon: pop strobe plus FIFO head and fill status.
interface cnt_wrap_mon_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
);
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  empty;
    logic                  full;
    logic [CNT_WIDTH-1:0]  level;

    modport master (output rd_en, input rd_data, empty, full, level);
    modport slave  (input rd_en, output rd_data, empty, full, level);
endinterface

// File: rtl/cnt_wrap_mon.sv
// Watches an external 4-bit counter, queues a timestamp for every max->0 wrap.
// Define CNT_WRAP_MON_CHK_EN to add the sticky counter-rule checker driving err.
module cnt_wrap_mon #(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int CNT_WIDTH  = ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0) ? ADDR_WIDTH + 1 : ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic [3:0]           max,
    input  logic [3:0]           cnt,
    input  logic                 err_clr,
    cnt_wrap_mon_if.slave        rd_if,
    output logic                 ovf,
    output logic                 err
);
    localparam logic [CNT_WIDTH-1:0]  DEPTH_C  = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(FIFO_DEPTH - 1);

    logic [DATA_WIDTH-1:0] ts;
    logic [3:0]            p_cnt;
    logic [3:0]            p_max;
    logic                  p_en;
    logic                  p_vld;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0]  level;

    logic empty_w;
    logic full_w;
    logic wrap_evt;
    logic pop;
    logic push;
    logic drop;

    function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty_w  = (level == '0);
    assign full_w   = (level == DEPTH_C);
    assign wrap_evt = p_vld & p_en & (p_cnt == p_max) & (cnt == 4'd0);
    assign pop      = rd_if.rd_en & ~empty_w;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign push     = wrap_evt & (~full_w | pop);
    assign drop     = wrap_evt & full_w & ~pop;

    assign rd_if.empty   = empty_w;
    assign rd_if.full    = full_w;
    assign rd_if.level   = level;
    assign rd_if.rd_data = empty_w ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ts     <= '0;
            p_cnt  <= '0;
            p_max  <= '0;
            p_en   <= 1'b0;
            p_vld  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            ts    <= ts + 1'b1;
            p_cnt <= cnt;
            p_max <= max;
            p_en  <= en;
            p_vld <= 1'b1;
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop)         ovf <= 1'b1;
            else if (err_clr) ovf <= 1'b0;
        end
    end

    // Timestamp storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= ts;
    end

`ifdef CNT_WRAP_MON_CHK_EN
    function automatic logic [3:0] exp_cnt(input logic e, input logic [3:0] c, input logic [3:0] m);
        if (!e)     return c;
        if (c == m) return 4'd0;
        return c + 4'd1;
    endfunction

    logic err_set;
    assign err_set = p_vld & (cnt != exp_cnt(p_en, p_cnt, p_max));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        err <= 1'b0;
        else if (err_set) err <= 1'b1;
        else if (err_clr) err <= 1'b0;
    end
`else
    assign err = 1'b0;
`endif

endmodule
